// File: rtl/pc_gen_if.sv
// Bundle between ctrl/id and the PC generator: stall, flush and branch redirects in; fetch address and status out.
// Signals only, no logic.
// Ports: stall, flush_i, flush_target_i, branch_flag_i, branch_target_i (to pc_gen); pc, ce, redirect_pending_o, misalign_o (from pc_gen).
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush_i;
    logic [ADDR_W-1:0]  flush_target_i;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending_o;
    logic               misalign_o;

    // Pipeline side: drives the redirect controls and observes the fetch address.
    modport master (
        output stall, flush_i, flush_target_i, branch_flag_i, branch_target_i,
        input  pc, ce, redirect_pending_o, misalign_o
    );

    // PC generator side.
    modport slave (
        input  stall, flush_i, flush_target_i, branch_flag_i, branch_target_i,
        output pc, ce, redirect_pending_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential step, flush/branch redirect, and a pending slot that holds branches seen during stall.
// Latency: one cycle from sampled inputs to pc; all outputs come straight from registers.
// Backpressure: stall[0] freezes pc; a branch taken under stall is queued and applied on release; a flush always applies.
// Ports: clk, rst (sync, active-high); bus (pc_gen_if.slave) carries the stall/flush/branch inputs and the pc/ce/status outputs.
module pc_gen #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter int                 INST_BYTES = 4,
    parameter int                 ALIGN_BITS = 1,
    parameter int                 STALL_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_if.slave     bus
);
    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Ones everywhere except the low ALIGN_BITS; ALIGN_BITS=0 leaves it all-ones.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              pend_vld_q, pend_vld_d;
    logic              mis_q, mis_d;

    logic              stall_pc;
    logic [ADDR_W-1:0] flush_tgt, branch_tgt;
    logic              flush_mis, branch_mis;

    assign stall_pc   = bus.stall[0];
    assign flush_tgt  = bus.flush_target_i & ALIGN_MASK;
    assign branch_tgt = bus.branch_target_i & ALIGN_MASK;
    assign flush_mis  = |(bus.flush_target_i & ~ALIGN_MASK);
    assign branch_mis = |(bus.branch_target_i & ~ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_vld_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            mis_q      <= mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        mis_d      = 1'b0;
        case (state_q)
            // Inputs are ignored here; pc already sits at RESET_VEC for the first fetch.
            S_OFF: state_d = S_START;
            S_START, S_RUN: begin
                state_d = S_RUN;
                if (bus.flush_i) begin
                    // A simultaneous branch is dropped, not captured.
                    pc_d       = flush_tgt;
                    pend_vld_d = 1'b0;
                    mis_d      = flush_mis;
                end else if (stall_pc) begin
                    if (bus.branch_flag_i) begin
                        // Newest branch overwrites any older pending one.
                        pend_tgt_d = branch_tgt;
                        pend_vld_d = 1'b1;
                        mis_d      = branch_mis;
                    end
                end else if (bus.branch_flag_i) begin
                    // Live branch supersedes a stale pending target.
                    pc_d       = branch_tgt;
                    pend_vld_d = 1'b0;
                    mis_d      = branch_mis;
                end else if (pend_vld_q) begin
                    // Misalignment was already reported when this target was captured.
                    pc_d       = pend_tgt_q;
                    pend_vld_d = 1'b0;
                end else begin
                    pc_d = pc_q + STEP;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign bus.pc                 = pc_q;
    assign bus.ce                 = (state_q != S_OFF);
    assign bus.redirect_pending_o = pend_vld_q;
    assign bus.misalign_o         = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random traffic, all checked against a rule-level reference model.
// Latency: model advanced at each posedge, DUT sampled 1 time unit later.
// Backpressure: stall[0] exercised directly and randomly.
module tb_pc_gen;
    localparam int          ADDR_W     = 32;
    localparam int          STALL_W    = 6;
    localparam logic [31:0] RESET_VEC  = 32'h100;
    localparam int          INST_BYTES = 4;
    localparam int          ALIGN_BITS = 1;
    localparam logic [31:0] GRAN       = 32'(2 ** ALIGN_BITS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus_if ();

    pc_gen #(
        .ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .INST_BYTES(INST_BYTES),
        .ALIGN_BITS(ALIGN_BITS), .STALL_W(STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: "running" flag, current pc, one pending slot, last misalign flag.
    logic        m_on, m_pv, m_mis;
    logic [31:0] m_pc, m_pt;

    function automatic logic [31:0] aligned(input logic [31:0] x);
        return x - (x % GRAN);
    endfunction

    function automatic logic odd(input logic [31:0] x);
        return (x % GRAN) != 0;
    endfunction

    task automatic model_edge();
        logic [31:0] ft, bt;
        ft = bus_if.flush_target_i;
        bt = bus_if.branch_target_i;
        if (rst) begin
            m_on = 1'b0; m_pc = RESET_VEC; m_pv = 1'b0; m_mis = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1; m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (bus_if.flush_i) begin
                m_pc = aligned(ft); m_pv = 1'b0; m_mis = odd(ft);
            end else if (bus_if.stall[0]) begin
                if (bus_if.branch_flag_i) begin
                    m_pt = aligned(bt); m_pv = 1'b1; m_mis = odd(bt);
                end
            end else if (bus_if.branch_flag_i) begin
                m_pc = aligned(bt); m_pv = 1'b0; m_mis = odd(bt);
            end else if (m_pv) begin
                m_pc = m_pt; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + 32'(INST_BYTES);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the sampled inputs, then every output is compared.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", bus_if.pc, m_pc);
        chk("ce", 32'(bus_if.ce), 32'(m_on));
        chk("pending", 32'(bus_if.redirect_pending_o), 32'(m_pv));
        chk("misalign", 32'(bus_if.misalign_o), 32'(m_mis));
    endtask

    task automatic drive(input logic s, input logic f, input logic [31:0] ft,
                         input logic b, input logic [31:0] bt);
        bus_if.stall           = {{(STALL_W-1){1'b0}}, s};
        bus_if.flush_i         = f;
        bus_if.flush_target_i  = ft;
        bus_if.branch_flag_i   = b;
        bus_if.branch_target_i = bt;
    endtask

    initial begin
        m_on = 1'b0; m_pv = 1'b0; m_mis = 1'b0; m_pc = RESET_VEC; m_pt = '0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);

        // Reset and start-up.
        rst = 1'b1;
        repeat (3) begin
            cyc();
            chk("rst_ce", 32'(bus_if.ce), 32'd0);
            chk("rst_pc", bus_if.pc, 32'h100);
        end
        rst = 1'b0;
        cyc(); chk("start_ce", 32'(bus_if.ce), 32'd1); chk("start_pc", bus_if.pc, 32'h100);
        cyc(); chk("seq1", bus_if.pc, 32'h104);
        cyc(); chk("seq2", bus_if.pc, 32'h108);

        // Wrap from top of address space.
        drive(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        cyc(); chk("wrap_top", bus_if.pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        cyc(); chk("wrap_zero", bus_if.pc, 32'h0);

        // Branch captured during stall, odd target.
        drive(1'b1, 1'b0, '0, 1'b1, 32'h2001);
        cyc();
        chk("stb_pend", 32'(bus_if.redirect_pending_o), 32'd1);
        chk("stb_mis", 32'(bus_if.misalign_o), 32'd1);
        chk("stb_hold", bus_if.pc, 32'h0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        cyc(); chk("stb_mis_clr", 32'(bus_if.misalign_o), 32'd0);
        cyc(); chk("stb_hold2", bus_if.pc, 32'h0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        cyc();
        chk("stb_apply", bus_if.pc, 32'h2000);
        chk("stb_pend_clr", 32'(bus_if.redirect_pending_o), 32'd0);
        cyc(); chk("stb_next", bus_if.pc, 32'h2004);

        // Newer stalled branch overwrites older.
        drive(1'b1, 1'b0, '0, 1'b1, 32'h40); cyc();
        drive(1'b1, 1'b0, '0, 1'b1, 32'h80); cyc();
        drive(1'b0, 1'b0, '0, 1'b0, '0);     cyc();
        chk("overwrite", bus_if.pc, 32'h80);

        // Flush beats pending and simultaneous branch.
        drive(1'b1, 1'b0, '0, 1'b1, 32'h300);       cyc();
        drive(1'b1, 1'b1, 32'h8, 1'b1, 32'h500);    cyc();
        chk("flush_pc", bus_if.pc, 32'h8);
        chk("flush_pend", 32'(bus_if.redirect_pending_o), 32'd0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);            cyc();
        drive(1'b0, 1'b0, '0, 1'b0, '0);            cyc();
        chk("flush_release", bus_if.pc, 32'hC);

        // Reset while a redirect is pending.
        drive(1'b1, 1'b0, '0, 1'b1, 32'h600); cyc();
        chk("rms_pend", 32'(bus_if.redirect_pending_o), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1; cyc();
        chk("rms_pend_clr", 32'(bus_if.redirect_pending_o), 32'd0);
        chk("rms_pc", bus_if.pc, RESET_VEC);
        chk("rms_ce", 32'(bus_if.ce), 32'd0);
        rst = 1'b0; cyc(); chk("rms_start", bus_if.pc, RESET_VEC);
        cyc(); chk("rms_no_stale", bus_if.pc, 32'h104);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ft, bt;
            ft = $urandom();
            bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, ft,
                  $urandom_range(0, 3) == 0, bt);
            bus_if.stall[STALL_W-1:1] = (STALL_W-1)'($urandom());
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
